// File: rtl/stack_cmd_issuer_pkg.sv
// Shared definitions for the stack-machine command issuer and its data path:
// command encodings, mirror-depth type and payload shaping helper.
package stack_cmd_issuer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_STACK_SIZE = 3;
  localparam int DEF_RD_LAT     = 1;

  // Widest word the half-word helper handles.
  localparam int MAX_DATA_WIDTH = 64;

  localparam logic [1:0] CTL_POP        = 2'b00;
  localparam logic [1:0] CTL_PUSH_HALF  = 2'b01;
  localparam logic [1:0] CTL_PUSH_FULL  = 2'b10;
  localparam logic [1:0] CTL_PUSH_SPLIT = 2'b11;

  // Mirror depth covers 0..STACK_SIZE inclusive.
  localparam int DEPTH_W = $clog2(DEF_STACK_SIZE + 1);
  typedef logic [DEPTH_W-1:0] depth_t;

  typedef logic [MAX_DATA_WIDTH-1:0] word_t;

  // Keep the low half of a dw-bit word and clear everything above it.
  function automatic word_t zext_half(input word_t d, input int unsigned dw);
    word_t mask;
    mask = (word_t'(1) << (dw / 2)) - word_t'(1);
    return d & mask;
  endfunction

endpackage

// File: rtl/stack_cmd_issuer_if.sv
// Request, stack-machine and result signals of the command issuer.
// master: the issuer itself; slave: upstream source, machine and consumer.
interface stack_cmd_issuer_if
  import stack_cmd_issuer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  req_valid;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_ready;

  logic [1:0]            ctl;
  logic [DATA_WIDTH-1:0] DATA_in;
  logic                  wait_in;
  logic [DATA_WIDTH-1:0] DATA_out;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  req_valid, req_op, req_data, wait_in, DATA_out,
    output req_ready, ctl, DATA_in, out_valid, out_data
  );

  modport slave (
    output req_valid, req_op, req_data, wait_in, DATA_out,
    input  req_ready, ctl, DATA_in, out_valid, out_data
  );
endinterface

// File: rtl/stack_result_tagger.sv
// Tracks whether each issued command will return a real word: an RD_LAT-deep
// tag shift pipeline, plus the register that captures DATA_out for real words.
module stack_result_tagger #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  pending_o
);

  logic [RD_LAT-1:0]     tag_q, tag_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // New tag enters at bit 0; the oldest tag sits at bit RD_LAT-1.
  always_comb begin
    tag_d = (tag_q << 1) | RD_LAT'(tag_i);
  end

  // Advance the tags; capture the machine's word only when its tag says it is real.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the tag stages are reset, unlike a data store: a stale 1 would fabricate a valid result.
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      out_valid_q <= tag_q[RD_LAT-1];
      if (tag_q[RD_LAT-1]) begin
        out_data_q <= data_out_i;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign pending_o   = |tag_q;

endmodule

// File: rtl/stack_cmd_issuer.sv
// Transmit-side driver for the stack machine: turns typed push/pop requests
// into one registered command per cycle, keeps a depth mirror so the machine
// is never overfilled, pops to drain, and tags the returned words.
module stack_cmd_issuer
  import stack_cmd_issuer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STACK_SIZE = DEF_STACK_SIZE,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  stack_cmd_issuer_if.master       bus,
  input  logic                     drain,
  output depth_t                   depth,
  output logic                     busy
);

  localparam depth_t DEPTH_FULL = depth_t'(STACK_SIZE);

  logic [1:0]            ctl_q, ctl_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  depth_t                depth_q, depth_d;
  logic                  accept;
  logic                  hold;
  logic                  tag;
  logic                  pending;

  // Pick this cycle's command by priority: stall, drain, make room, request, idle pop.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctl_d  = CTL_POP;
    accept = 1'b0;
    hold   = 1'b0;
    if (bus.wait_in) begin
      // Machine is stalled: present 00 but treat it as a hold, not a pop.
      hold = 1'b1;
    end else if (drain && depth_q != '0) begin
      ctl_d = CTL_POP;
    end else if (bus.req_valid && bus.req_op == CTL_PUSH_SPLIT && depth_q == DEPTH_FULL) begin
      ctl_d = CTL_POP;
    end else if (bus.req_valid) begin
      ctl_d  = bus.req_op;
      accept = 1'b1;
    end
  end

  // Shape the payload for the chosen command.
  always_comb begin
    unique case (ctl_d)
      CTL_PUSH_HALF:                 data_in_d = DATA_WIDTH'(zext_half(word_t'(bus.req_data), DATA_WIDTH));
      CTL_PUSH_FULL, CTL_PUSH_SPLIT: data_in_d = bus.req_data;
      default:                       data_in_d = '0;
    endcase
  end

  // Mirror the machine's depth and decide whether this command returns a real word.
  always_comb begin
    depth_d = depth_q;
    if (!hold) begin
      unique case (ctl_d)
        CTL_POP:        if (depth_q != '0) depth_d = depth_q - depth_t'(1);
        CTL_PUSH_SPLIT: depth_d = depth_q + depth_t'(1);
        default:        depth_d = depth_q;
      endcase
    end
    tag = !hold && !(ctl_d == CTL_POP && depth_q == '0);
  end

  // Register the issued command, its payload and the mirror depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q     <= CTL_POP;
      data_in_q <= '0;
      depth_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      ctl_q     <= ctl_d;
      data_in_q <= data_in_d;
      depth_q   <= depth_d;
    end
  end

  stack_result_tagger #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_tagger (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag),
    .data_out_i  (bus.DATA_out),
    .out_valid_o (bus.out_valid),
    .out_data_o  (bus.out_data),
    .pending_o   (pending)
  );

  assign bus.req_ready = rst && accept;
  assign bus.ctl       = ctl_q;
  assign bus.DATA_in   = data_in_q;
  assign depth         = depth_q;
  assign busy          = (depth_q != '0) || pending;

endmodule

// File: tb/tb_stack_cmd_issuer.sv
// Bench for stack_cmd_issuer: a behavioural stack-machine model answers the
// commands, a queue-based reference predicts every output each cycle, and a
// directed prologue pins the reference with hand-computed values.
module tb_stack_cmd_issuer;
  import stack_cmd_issuer_pkg::*;

  localparam int DW = 32;
  localparam int SS = 3;
  localparam int RL = 1;

  logic   clk   = 1'b0;
  logic   rst   = 1'b0;
  logic   drain = 1'b0;
  depth_t depth;
  logic   busy;

  stack_cmd_issuer_if #(.DATA_WIDTH(DW)) bus ();

  stack_cmd_issuer #(
    .DATA_WIDTH (DW),
    .STACK_SIZE (SS),
    .RD_LAT     (RL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .drain (drain),
    .depth (depth),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference: logical stack of upper halves ----------------
  typedef struct packed { logic v; logic [31:0] w; } res_t;

  res_t        pipe[$];
  logic [15:0] ref_stk[$];
  logic [1:0]  exp_ctl       = 2'b00;
  logic [31:0] exp_din       = '0;
  logic        exp_out_valid = 1'b0;
  logic [31:0] exp_out_data  = '0;
  bit          live          = 1'b0;

  function automatic logic exp_ready();
    if (!rst || bus.wait_in) return 1'b0;
    if (drain && ref_stk.size() > 0) return 1'b0;
    if (bus.req_valid && bus.req_op == 2'b11 && ref_stk.size() == SS) return 1'b0;
    return bus.req_valid;
  endfunction

  function automatic logic exp_busy();
    if (ref_stk.size() != 0) return 1'b1;
    foreach (pipe[i]) if (pipe[i].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    res_t        head, e;
    logic [1:0]  cmd;
    logic [31:0] d;
    logic [15:0] top;
    d    = bus.req_data;
    live = 1'b1;
    if (!rst) begin
      ref_stk.delete();
      pipe.delete();
      for (int i = 0; i < RL; i++) pipe.push_back('0);
      exp_ctl       = 2'b00;
      exp_din       = '0;
      exp_out_valid = 1'b0;
      exp_out_data  = '0;
      return;
    end
    head          = pipe.pop_front();
    exp_out_valid = head.v;
    if (head.v) exp_out_data = head.w;
    cmd = exp_ready() ? bus.req_op : 2'b00;
    e   = '0;
    if (!bus.wait_in) begin
      case (cmd)
        2'b00: if (ref_stk.size() > 0) begin
                 top = ref_stk.pop_back();
                 e   = {1'b1, 16'h0, top};
               end
        2'b01: e = {1'b1, 16'h0, d[15:0]};
        2'b10: e = {1'b1, d};
        default: begin
          e = {1'b1, 16'h0, d[15:0]};
          ref_stk.push_back(d[31:16]);
        end
      endcase
    end
    exp_ctl = cmd;
    exp_din = (cmd == 2'b00) ? 32'h0 : (cmd == 2'b01) ? {16'h0, d[15:0]} : d;
    pipe.push_back(e);
  endtask

  always @(posedge clk) model_step();

  // ---------------- stack machine model (answers within one cycle) ----------------
  logic [15:0] mstk[$];
  logic        mach_rst;

  task automatic mach_step(input logic r);
    logic [15:0] t;
    if (!r) begin
      mstk.delete();
      bus.DATA_out = '0;
      return;
    end
    case (bus.ctl)
      2'b00: if (mstk.size() > 0) begin
               t = mstk.pop_back();
               bus.DATA_out = {16'h0, t};
             end else begin
               bus.DATA_out = '0;
             end
      2'b01, 2'b10: bus.DATA_out = bus.DATA_in;
      default: begin
        check("mach_room_for_split", 32'(mstk.size() < SS), 32'd1);
        bus.DATA_out = {16'h0, bus.DATA_in[15:0]};
        mstk.push_back(bus.DATA_in[31:16]);
      end
    endcase
  endtask

  always @(posedge clk) begin
    mach_rst = rst;
    #1;
    mach_step(mach_rst);
  end

  // ---------------- per-cycle compare, on the falling edge ----------------
  always @(negedge clk) begin
    if (live) begin
      check("ctl",       32'(bus.ctl),       32'(exp_ctl));
      check("DATA_in",   bus.DATA_in,        exp_din);
      check("depth",     32'(depth),         32'(ref_stk.size()));
      check("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
      check("out_data",  bus.out_data,       exp_out_data);
      check("busy",      32'(busy),          32'(exp_busy()));
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic rv, input logic [1:0] op, input logic [31:0] d, input logic drn);
    bus.req_valid = rv;
    bus.req_op    = op;
    bus.req_data  = d;
    drain         = drn;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic       drn;
    logic [1:0] op;
    bus.wait_in  = 1'b0;
    bus.DATA_out = '0;
    set_in(1'b1, 2'b10, 32'hCAFE_0001, 1'b0);
    #1 check("ready_in_reset", 32'(bus.req_ready), 32'd0);

    // Reset state
    tick(); tick();
    check("rst_ctl",       32'(bus.ctl),       32'd0);
    check("rst_DATA_in",   bus.DATA_in,        32'd0);
    check("rst_depth",     32'(depth),         32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  bus.out_data,       32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    rst = 1'b1;

    // Idle five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ctl",       32'(bus.ctl),       32'd0);
      check("idle_DATA_in",   bus.DATA_in,        32'd0);
      check("idle_depth",     32'(depth),         32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // push-full at depth 0
    set_in(1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0);
    #1 check("full_ready", 32'(bus.req_ready), 32'd1);
    tick();
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    check("full_ctl",     32'(bus.ctl), 32'd2);
    check("full_DATA_in", bus.DATA_in,  32'hDEAD_BEEF);
    check("full_depth",   32'(depth),   32'd0);
    tick();
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_out_data",  bus.out_data,       32'hDEAD_BEEF);

    // push-half zero-extends
    set_in(1'b1, 2'b01, 32'hABCD_1357, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    check("half_DATA_in", bus.DATA_in, 32'h0000_1357);
    tick();

    // push-split then idle pop
    set_in(1'b1, 2'b11, 32'h1234_5678, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    check("split_ctl",     32'(bus.ctl), 32'd3);
    check("split_DATA_in", bus.DATA_in,  32'h1234_5678);
    check("split_depth",   32'(depth),   32'd1);
    tick();
    check("split_out_valid", 32'(bus.out_valid), 32'd1);
    check("split_out_data",  bus.out_data,       32'h0000_5678);
    check("autopop_ctl",     32'(bus.ctl),       32'd0);
    check("autopop_depth",   32'(depth),         32'd0);
    tick();
    check("autopop_out_valid", 32'(bus.out_valid), 32'd1);
    check("autopop_out_data",  bus.out_data,       32'h0000_1234);
    tick();
    check("hold_out_valid", 32'(bus.out_valid), 32'd0);
    check("hold_out_data",  bus.out_data,       32'h0000_1234);

    // Fill to STACK_SIZE, fourth split must wait for a pop
    set_in(1'b1, 2'b11, 32'h1111_2222, 1'b0); tick();
    set_in(1'b1, 2'b11, 32'h3333_4444, 1'b0); tick();
    set_in(1'b1, 2'b11, 32'h5555_6666, 1'b0); tick();
    check("fill_depth", 32'(depth), 32'd3);
    set_in(1'b1, 2'b11, 32'h7777_8888, 1'b0);
    #1 check("full_stall_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("room_pop_ctl",   32'(bus.ctl), 32'd0);
    check("room_pop_depth", 32'(depth),   32'd2);
    #1 check("after_room_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("fourth_ctl",     32'(bus.ctl), 32'd3);
    check("fourth_DATA_in", bus.DATA_in,  32'h7777_8888);
    check("fourth_depth",   32'(depth),   32'd3);
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    repeat (5) tick();

    // drain wins over a pending request at depth 2
    set_in(1'b1, 2'b11, 32'hAAAA_BBBB, 1'b0); tick();
    set_in(1'b1, 2'b11, 32'hCCCC_DDDD, 1'b0); tick();
    set_in(1'b1, 2'b10, 32'hF00D_F00D, 1'b1);
    #1 check("drain_ready_d2", 32'(bus.req_ready), 32'd0);
    tick();
    check("drain_ctl1",   32'(bus.ctl), 32'd0);
    check("drain_depth1", 32'(depth),   32'd1);
    #1 check("drain_ready_d1", 32'(bus.req_ready), 32'd0);
    tick();
    check("drain_ctl2",      32'(bus.ctl),       32'd0);
    check("drain_depth2",    32'(depth),         32'd0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd1);
    check("drain_out_data1", bus.out_data,       32'h0000_CCCC);
    #1 check("drain_ready_d0", 32'(bus.req_ready), 32'd1);
    tick();
    check("resume_ctl",      32'(bus.ctl), 32'd2);
    check("drain_out_data2", bus.out_data, 32'h0000_AAAA);
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    repeat (3) tick();

    // Reset mid-operation with tags in flight
    set_in(1'b1, 2'b11, 32'h0102_0304, 1'b0); tick();
    set_in(1'b1, 2'b11, 32'h0506_0708, 1'b0); tick();
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_depth",     32'(depth),         32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ctl",       32'(bus.ctl),       32'd0);
    check("midrst_busy",      32'(busy),          32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // wait_in stalls issue at depth 0
    bus.wait_in = 1'b1;
    set_in(1'b1, 2'b10, 32'h5A5A_5A5A, 1'b0);
    #1 check("wait_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("wait_ctl",   32'(bus.ctl), 32'd0);
    check("wait_depth", 32'(depth),   32'd0);
    bus.wait_in = 1'b0;
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    repeat (2) tick();

    // Randomized traffic, reference-checked every cycle
    drn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 19) == 0) drn = !drn;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) op = 2'b11;
      set_in($urandom_range(0, 9) < 7, op, $urandom, drn);
      tick();
    end
    rst = 1'b1;
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_cmd_issuer.md
Name: stack_cmd_issuer

Overview:
- Transmit-side driver for the 3-deep stack-machine data path; generates the `ctl`/`DATA_in` command stream the stack machine consumes and collects its `DATA_out` word stream.
- Accepts typed push/pop requests from an upstream valid/ready source.
- Keeps a mirror of stack depth so it never overflows the machine; inserts pops to drain.
- Tags each returned word valid or invalid and presents it downstream.

Parameters:
- DATA_WIDTH, 32, command/result word width; must be even.
- STACK_SIZE, 3, stack-machine depth; sets mirror depth range 0..STACK_SIZE.
- RD_LAT, 1, cycles from `ctl` issue to the matching `DATA_out` sample.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- req_valid  in  1  upstream request present.
- req_op  in  2  00 pop, 01 push-half, 10 push-full, 11 push-split.
- req_data  in  DATA_WIDTH  request payload.
- req_ready  out  1  request accepted this cycle when `req_valid` & `req_ready`.
- drain  in  1  level; forces pops until mirror depth is 0.
- ctl  out  2  command to the stack machine.
- DATA_in  out  DATA_WIDTH  payload to the stack machine.
- wait_in  in  1  stack machine `o_wait`; stalls issue.
- DATA_out  in  DATA_WIDTH  stack machine result.
- out_valid  out  1  `out_data` holds a real result.
- out_data  out  DATA_WIDTH  result word.
- depth  out  2  mirror depth, 0..STACK_SIZE.
- busy  out  1  depth≠0, or result pipeline non-empty.

Behaviour:
- Reset (`rst`=0 at a clock edge): `ctl`=00, `DATA_in`=0, `req_ready`=0, `out_valid`=0, `out_data`=0, `depth`=0, `busy`=0, result-tag pipeline cleared. Reset mid-operation discards all in-flight tags; the stack machine is reset by the same signal.
- `ctl` and `DATA_in` are registered; exactly one command is issued per cycle.
- Idle issue, when no request is accepted: `ctl`=00, `DATA_in`=0.
- Mirror depth update per issued `ctl`:
  - 00 → max(depth−1, 0).
  - 01 / 10 → depth unchanged.
  - 11 → depth+1.
- Depth limit: 11 is never issued at depth = STACK_SIZE. The mirror therefore never reaches the machine's 11-at-full path, and `wait_in` should never rise.
- Payload shaping:
  - 01 → `DATA_in` = {0, `req_data`[DW/2−1:0]}.
  - 10 → `DATA_in` = `req_data`.
  - 11 → `DATA_in` = `req_data` (the machine splits it).
  - 00 → `DATA_in` = 0.
- Issue priority, evaluated each cycle:
  1. `wait_in`=1 → issue 00-idle only if depth=0, else hold `ctl`=00 with no request accepted; `req_ready`=0.
  2. `drain`=1 and depth>0 → issue 00 (pop); `req_ready`=0.
  3. `req_valid`=1, op=11, depth=STACK_SIZE → issue 00 (pop) to make room; `req_ready`=0 this cycle; request accepted on a later cycle.
  4. `req_valid`=1 otherwise → issue `req_op`; `req_ready`=1.
  5. Else issue 00. At depth>0 this pops: the stack auto-drains when upstream idles.
- `req_ready` is combinational from `req_valid`, `req_op`, `depth`, `drain`, `wait_in`.
- Result tag: every issued command pushes tag = NOT(`ctl`=00 AND depth=0 before issue) into an RD_LAT-deep shift pipeline.
- Result output: `out_valid` = tag leaving the pipeline; `out_data` = `DATA_out` registered on the same edge. When `out_valid`=0, `out_data` holds its last value.
- There is no downstream backpressure: results are lost if the consumer is not ready, and the consumer is sized accordingly.
- Simultaneous `drain` and `req_valid`: drain wins until depth=0, then requests resume on the next cycle.
- `busy` deasserts only when depth=0 and no tag=1 remains in the pipeline.

Decomposition:
- Shared package holds:
  - CTL_POP=2'b00, CTL_PUSH_HALF=2'b01, CTL_PUSH_FULL=2'b10, CTL_PUSH_SPLIT=2'b11.
  - Depth type sized by STACK_SIZE.
  - The half-word zero-extend function.
- The stack-machine data path imports the same constants.
- One sub-module: `stack_result_tagger` (RD_LAT shift pipeline of tags plus the `out_data` register).

Test Plan:
- Reset then idle 5 cycles → `ctl`=00 each cycle, `depth`=0, `out_valid`=0 throughout.
- push-full 0xDEADBEEF at depth 0 → `ctl`=10, `DATA_in`=0xDEADBEEF; RD_LAT+1 cycles later `out_valid`=1, `out_data`=0xDEADBEEF; `depth` stays 0.
- push-split 0x12345678 at depth 0 → `out_data`=0x00005678 valid, `depth`=1; next idle cycle pops `out_data`=0x00001234 valid, `depth`=0.
- Three back-to-back push-split at depth 0, then a fourth with `req_valid` held → `depth` reaches 3; fourth request stalls with `req_ready`=0 for one cycle while a 00 pop issues, then it is accepted; `depth` never exceeds 3.
- `drain`=1 at depth 2 with `req_valid`=1 → two 00 pops issue, each yielding a valid word; `req_ready`=1 only once `depth`=0.
- `rst`=0 asserted at depth 2 with tags in flight → next cycle `depth`=0, `out_valid`=0, `ctl`=00, `busy`=0.
